mips_cpu_lsu: RTL and testbench
===============================

MIPS_CPU_LSU -- requirements
Module: mips_cpu_lsu

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 255, cycles of continuous waitrequest tolerated before the access is aborted.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  CPU access request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  lsu_size_t: BYTE, HALF, WORD.
- req_signed  in  1  sign-extend load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- busy  out  1  access in flight; requests ignored.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misalign or timeout.
- resp_rdata  out  32  extended load data, valid with resp_valid.
- address  out  32  bus word address {req_addr[31:2],2'b00}.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- byteenable  out  4  bus lane enables.
- writedata  out  32  lane-replicated store data.
- waitrequest  in  1  slave stall.
- readdata  in  32  slave data, registered, valid one cycle after the completing edge.

Function
REQ-003 SHALL use FSM states IDLE, ACCESS, CAPTURE; busy=1 in any state other than IDLE.
REQ-004 In IDLE, req_valid=1 SHALL register address/size/signed/byteenable/writedata and enter ACCESS next cycle; req_valid with busy=1 SHALL be ignored.
REQ-005 byteenable SHALL be: BYTE 4'b0001<<addr[1:0]; HALF addr[1]?4'b1100:4'b0011; WORD 4'b1111.
REQ-006 writedata SHALL be: BYTE {4{wdata[7:0]}}; HALF {2{wdata[15:0]}}; WORD wdata.
REQ-007 In ACCESS, read/write and address/byteenable/writedata SHALL be held constant while waitrequest=1.
REQ-008 At the ACCESS edge with waitrequest=0: store SHALL go to IDLE and pulse resp_valid the next cycle; load SHALL go to CAPTURE.
REQ-009 In CAPTURE, read=0; readdata SHALL be shifted right by 8*addr[1:0] and sign- or zero-extended per size/signed into resp_rdata, with resp_valid pulsed on entering IDLE.
REQ-010 Total latency with waitrequest=0 throughout: store 2 cycles, load 3 cycles from accepting edge to resp_valid.
REQ-011 A wait counter SHALL count ACCESS cycles with waitrequest=1; reaching MAX_WAIT SHALL drop read/write, return to IDLE, pulse resp_valid with resp_err=1, resp_rdata=0.
REQ-012 A request SHALL be accepted in the same cycle resp_valid is high (back-to-back).
REQ-013 resp_rdata SHALL hold its last value outside resp_valid; resp_err=0 on success.

Reset
REQ-014 reset SHALL force state IDLE, read=0, write=0, resp_valid=0, resp_err=0, resp_rdata=0, byteenable=0, address=0, writedata=0, counter=0 at the next clk edge, including mid-ACCESS/CAPTURE; in-flight response is discarded.

Configuration
REQ-015 Macro LSU_ALIGN_CHECK_EN defined: HALF with addr[0]=1 or WORD with addr[1:0]!=0 SHALL issue no bus cycle and pulse resp_valid, resp_err=1 the next cycle.
REQ-016 Without LSU_ALIGN_CHECK_EN: misaligned HALF/WORD SHALL ignore the offending low address bits (forced to 0) and complete normally.

Structure
REQ-017 Package mips_lsu_pkg SHALL hold lsu_size_t, the state enum, and byteenable constants.
REQ-018 Sub-module mips_lsu_lane SHALL hold the combinational byteenable/writedata/extract-extend logic; the FSM and counter stay in mips_cpu_lsu.

Verification
REQ-019 Store WORD 0xDEADBEEF at 0xBFC00010, waitrequest 0 -> write=1, byteenable=4'b1111, address=0xBFC00010; resp_valid 2 cycles after accept.
REQ-020 Load BYTE signed at 0xBFC00013, memory word 0x80112233 -> byteenable=4'b1000; resp_rdata=0xFFFFFF80.
REQ-021 Load HALF unsigned at 0xBFC00002, waitrequest alternating 1/0 -> strobes held stable; resp_rdata=0x00008011.
REQ-022 MAX_WAIT=4, waitrequest stuck 1 -> read drops after 4 stall cycles; resp_valid=1, resp_err=1, resp_rdata=0.
REQ-023 reset asserted in ACCESS -> read=0, busy=0 next cycle, no resp_valid; then a SW/LW to the same address returns the stored value.
REQ-024 With LSU_ALIGN_CHECK_EN, LW at 0xBFC00002 -> no read strobe, resp_err=1 next cycle; without it, word at 0xBFC00000 returned.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg -- shared types and constants for the MIPS load/store unit.
//   lsu_size_t     : access width (BYTE, HALF, WORD)
//   lsu_state_t    : LSU control states (IDLE, ACCESS, CAPTURE)
//   lsu_req_t      : request attributes latched at accept time
//   BE_*           : bus byte-enable patterns
//   lsu_eff_off()  : lane offset with misaligned low bits forced to zero
//   lsu_misaligned(): natural-alignment test used when LSU_ALIGN_CHECK_EN is set
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic      write;
    lsu_size_t size;
    logic      sgn;
    logic [1:0] off;
  } lsu_req_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Low address bits that cannot be honoured for the size are dropped, so a
  // misaligned access degrades to the naturally aligned one containing it.
  function automatic logic [1:0] lsu_eff_off(lsu_size_t sz, logic [1:0] lo);
    case (sz)
      BYTE:    return lo;
      HALF:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic lsu_misaligned(lsu_size_t sz, logic [1:0] lo);
    case (sz)
      BYTE:    return 1'b0;
      HALF:    return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// mips_lsu_lane -- combinational lane steering for the LSU.
//   enc_size/enc_off/enc_data -> enc_be, enc_wdata : bus byte enables and
//                                lane-replicated store data for a request
//   dec_size/dec_signed/dec_off/dec_word -> dec_data : load data shifted down
//                                to bit 0 and sign/zero extended
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  lsu_size_t   enc_size,
  input  logic [1:0]  enc_off,
  input  logic [31:0] enc_data,
  output logic [3:0]  enc_be,
  output logic [31:0] enc_wdata,
  input  lsu_size_t   dec_size,
  input  logic        dec_signed,
  input  logic [1:0]  dec_off,
  input  logic [31:0] dec_word,
  output logic [31:0] dec_data
);

  logic [31:0] shifted;

  // Store data is replicated across all lanes so the slave finds it under
  // whichever byte enables are set.
  always_comb begin
    enc_be    = BE_WORD;
    enc_wdata = enc_data;
    case (enc_size)
      BYTE: begin
        enc_be    = BE_BYTE0 << enc_off;
        enc_wdata = {4{enc_data[7:0]}};
      end
      HALF: begin
        enc_be    = enc_off[1] ? BE_HALF_HI : BE_HALF_LO;
        enc_wdata = {2{enc_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = dec_word >> {dec_off, 3'b000};

  always_comb begin
    dec_data = shifted;
    case (dec_size)
      BYTE:    dec_data = {{24{dec_signed & shifted[7]}},  shifted[7:0]};
      HALF:    dec_data = {{16{dec_signed & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu -- single-outstanding load/store unit between CPU and a
// waitrequest-style memory bus.
//   Parameter MAX_WAIT : consecutive stall cycles tolerated before abort.
//   CPU side : req_valid/req_write/req_size/req_signed/req_addr/req_wdata in,
//              busy, resp_valid/resp_err/resp_rdata out.
//   Bus side : address/read/write/byteenable/writedata out,
//              waitrequest/readdata in (readdata one cycle after completion).
//   Optional : define LSU_ALIGN_CHECK_EN to reject misaligned HALF/WORD
//              requests with resp_err instead of truncating the address.
module mips_cpu_lsu
  import mips_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  lsu_size_t   req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_t    state, state_nxt;
  lsu_req_t      req_q;
  logic [CW-1:0] wait_cnt;
  logic          wait_last;
  logic          misalign;
  logic [1:0]    req_off;
  logic          accept, reject, stall, timeout, store_done, load_done;
  logic [3:0]    enc_be;
  logic [31:0]   enc_wdata, dec_data;

  assign req_off   = lsu_eff_off(req_size, req_addr[1:0]);
  assign wait_last = (wait_cnt == CW'(MAX_WAIT - 1));

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = lsu_misaligned(req_size, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mips_lsu_lane u_lane (
    .enc_size   (req_size),
    .enc_off    (req_off),
    .enc_data   (req_wdata),
    .enc_be     (enc_be),
    .enc_wdata  (enc_wdata),
    .dec_size   (req_q.size),
    .dec_signed (req_q.sgn),
    .dec_off    (req_q.off),
    .dec_word   (readdata),
    .dec_data   (dec_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && !misalign) state_nxt = ACCESS;
      ACCESS: begin
        if (!waitrequest)   state_nxt = req_q.write ? IDLE : CAPTURE;
        else if (wait_last) state_nxt = IDLE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and per-state events. Strobes come straight from the state
  // register, so an abort or reset drops them together with the state.
  always_comb begin
    busy       = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    stall      = 1'b0;
    timeout    = 1'b0;
    store_done = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        accept = req_valid && !misalign;
        reject = req_valid && misalign;
      end
      ACCESS: begin
        read       = !req_q.write;
        write      = req_q.write;
        stall      = waitrequest;
        timeout    = waitrequest && wait_last;
        store_done = !waitrequest && req_q.write;
      end
      CAPTURE: load_done = 1'b1;
      default: ;
    endcase
  end

  // Request latch, wait counter and response registers. Bus fields only
  // change on accept, which keeps them stable through any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        req_q      <= '{write: req_write, size: req_size, sgn: req_signed, off: req_off};
        address    <= {req_addr[31:2], 2'b00};
        byteenable <= enc_be;
        writedata  <= enc_wdata;
        wait_cnt   <= '0;
      end
      if (stall && !timeout) wait_cnt <= wait_cnt + CW'(1);
      if (store_done) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
      end
      if (load_done) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= dec_data;
      end
      if (timeout || reject) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
module tb_mips_cpu_lsu;
  import mips_lsu_pkg::*;

  localparam int MW = 4;

  logic        clk, reset;
  logic        req_valid, req_write, req_signed;
  lsu_size_t   req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int n_chk = 0, n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .address(address),
    .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  // ---------------- bus slave (word memory, 1 KiB window) ----------------
  logic [31:0] smem [0:255];
  logic [7:0]  rmem [0:1023];   // reference byte memory
  logic        mem_init;
  logic [31:0] sl_w;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 256; w++)
        smem[w] <= {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    end else begin
      if (read && !waitrequest) readdata <= smem[address[9:2]];
      else                      readdata <= $urandom();
      if (write && !waitrequest) begin
        sl_w = smem[address[9:2]];
        for (int j = 0; j < 4; j++)
          if (byteenable[j]) sl_w[8*j +: 8] = writedata[8*j +: 8];
        smem[address[9:2]] <= sl_w;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(lsu_size_t s);
    return (s == BYTE) ? 1 : (s == HALF) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_eff(logic [31:0] a, lsu_size_t s);
    return a - (a % nbytes(s));
  endfunction

  function automatic logic ref_err(logic [31:0] a, lsu_size_t s);
`ifdef LSU_ALIGN_CHECK_EN
    return (a % nbytes(s)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, lsu_size_t s, logic sg);
    longint unsigned v;
    int n;
    logic [31:0] e;
    logic [9:0] ix;
    v = 0; n = nbytes(s); e = ref_eff(a, s);
    for (int i = 0; i < n; i++) begin
      ix = e[9:0] + 10'(i);
      v += longint'(rmem[ix]) << (8 * i);
    end
    if (sg && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(logic [31:0] a, lsu_size_t s);
    logic [3:0] b;
    logic [31:0] e;
    b = '0; e = ref_eff(a, s);
    for (int i = 0; i < nbytes(s); i++) b[int'(e[1:0]) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] ref_wd(logic [31:0] wd, lsu_size_t s);
    logic [31:0] r, t;
    for (int j = 0; j < 4; j++) begin
      t = wd >> (8 * (j % nbytes(s)));
      r[8*j +: 8] = t[7:0];
    end
    return r;
  endfunction

  function automatic void ref_store(logic [31:0] a, lsu_size_t s, logic [31:0] wd);
    logic [31:0] e, t;
    logic [9:0] ix;
    e = ref_eff(a, s);
    for (int i = 0; i < nbytes(s); i++) begin
      ix = e[9:0] + 10'(i);
      t = wd >> (8 * i);
      rmem[ix] = t[7:0];
    end
  endfunction

  function automatic void put_word(logic [31:0] a, logic [31:0] v);
    for (int i = 0; i < 4; i++) rmem[a[9:0] + 10'(i)] = v[8*i +: 8];
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        brd, bwr;
    int          strobes, stalls;
    logic        stable;
  } obs_t;

  // mode: 0 no stall, 1 alternate 1/0, 2 random (<=2 in a row), 3 stuck
  task automatic do_txn(input logic wr, input lsu_size_t sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int mode, output obs_t o);
    int consec;
    o = '{lat: -1, err: 1'b0, rd: '0, addr: '0, wd: '0, be: '0, brd: 1'b0,
          bwr: 1'b0, strobes: 0, stalls: 0, stable: 1'b1};
    consec = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int n = 1; n <= 40; n++) begin
      if (resp_valid) begin
        o.lat = n; o.err = resp_err; o.rd = resp_rdata;
        break;
      end
      if (read || write) begin
        if (o.strobes == 0) begin
          o.brd = read; o.bwr = write; o.addr = address; o.be = byteenable; o.wd = writedata;
        end else if ({read, write, address, byteenable, writedata} !=
                     {o.brd, o.bwr, o.addr, o.be, o.wd}) begin
          o.stable = 1'b0;
        end
        o.strobes++;
        case (mode)
          0:       waitrequest = 1'b0;
          1:       waitrequest = (o.strobes % 2) == 1;
          2:       waitrequest = (consec < 2) && ($urandom_range(0, 2) == 0);
          default: waitrequest = 1'b1;
        endcase
        if (waitrequest) begin o.stalls++; consec++; end
        else consec = 0;
      end else begin
        waitrequest = 1'b0;
      end
      // junk requests while busy must be ignored
      req_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom();
      req_wdata = $urandom();
      @(negedge clk);
    end
    req_valid = 1'b0; waitrequest = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic wr, input logic [31:0] a,
                           input obs_t o, input logic e_err, input int e_lat,
                           input logic [3:0] e_be, input logic [31:0] e_wd,
                           input logic [31:0] e_rd);
    chk({tag, "_lat"}, 32'(o.lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(o.err), 32'(e_err));
    if (e_err) begin
      chk({tag, "_nobus"}, 32'(o.strobes), 32'd0);
      chk({tag, "_rd0"}, o.rd, 32'd0);
    end else begin
      chk({tag, "_addr"}, o.addr, a & 32'hFFFF_FFFC);
      chk({tag, "_be"}, 32'(o.be), 32'(e_be));
      chk({tag, "_kind"}, {30'd0, o.brd, o.bwr}, {30'd0, !wr, wr});
      chk({tag, "_stable"}, 32'(o.stable), 32'd1);
      if (wr) chk({tag, "_wd"}, o.wd, e_wd);
      else    chk({tag, "_rd"}, o.rd, e_rd);
    end
  endtask

  typedef struct {
    logic        wr;
    lsu_size_t   sz;
    logic        sg;
    logic [31:0] a, wd;
    int          mode;
    logic        err;
    int          lat;
    logic [3:0]  be;
    logic [31:0] bwd, rd;
  } vec_t;

  vec_t vt[$];
  obs_t o;

  task automatic reset_mid(input int depth);
    int cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = WORD; req_signed = 1'b0;
    req_addr = 32'hBFC0_0020; waitrequest = (depth == 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("rst%0d_pre_read", depth), 32'(read), 32'd1);
    if (depth == 2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rst%0d_read", depth), 32'(read), 32'd0);
    chk($sformatf("rst%0d_busy", depth), 32'(busy), 32'd0);
    chk($sformatf("rst%0d_resp", depth), 32'(resp_valid), 32'd0);
    chk($sformatf("rst%0d_be", depth), {28'd0, byteenable}, 32'd0);
    chk($sformatf("rst%0d_addr", depth), address, 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk($sformatf("rst%0d_quiet", depth), 32'(cnt), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic        wr, sg, e_err;
    lsu_size_t   sz;
    logic [31:0] a, wd, held;
    int          mode;

    reset = 1'b1; mem_init = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_size = BYTE; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    waitrequest = 1'b0;
    for (int i = 0; i < 1024; i++) rmem[i] = 8'($urandom());
    put_word(32'hBFC0_0000, 32'h8011_2233);
    put_word(32'hBFC0_0010, 32'h8011_2233);
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_strobes", {30'd0, read, write}, 32'd0);
    chk("reset_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_bus", address | writedata | {28'd0, byteenable}, 32'd0);
    reset = 1'b0;

    // wr sz sg addr wdata mode | err lat be writedata rdata
    vt.push_back('{0, BYTE, 1, 32'hBFC0_0013, 0, 0, 0, 3, 4'b1000, 0, 32'hFFFF_FF80});
    vt.push_back('{0, BYTE, 0, 32'hBFC0_0013, 0, 0, 0, 3, 4'b1000, 0, 32'h0000_0080});
    vt.push_back('{0, HALF, 0, 32'hBFC0_0002, 0, 1, 0, 4, 4'b1100, 0, 32'h0000_8011});
    vt.push_back('{0, HALF, 1, 32'hBFC0_0002, 0, 0, 0, 3, 4'b1100, 0, 32'hFFFF_8011});
    vt.push_back('{0, HALF, 1, 32'hBFC0_0000, 0, 0, 0, 3, 4'b0011, 0, 32'h0000_2233});
    vt.push_back('{1, WORD, 0, 32'hBFC0_0010, 32'hDEAD_BEEF, 0, 0, 2, 4'b1111, 32'hDEAD_BEEF, 0});
    vt.push_back('{0, WORD, 0, 32'hBFC0_0010, 0, 0, 0, 3, 4'b1111, 0, 32'hDEAD_BEEF});
    vt.push_back('{1, BYTE, 0, 32'hBFC0_0011, 32'h0000_00A5, 0, 0, 2, 4'b0010, 32'hA5A5_A5A5, 0});
    vt.push_back('{0, WORD, 0, 32'hBFC0_0010, 0, 0, 0, 3, 4'b1111, 0, 32'hDEAD_A5EF});
    vt.push_back('{1, HALF, 0, 32'hBFC0_0012, 32'hFFFF_1234, 1, 0, 3, 4'b1100, 32'h1234_1234, 0});
    vt.push_back('{0, WORD, 0, 32'hBFC0_0010, 0, 0, 0, 3, 4'b1111, 0, 32'h1234_A5EF});
`ifdef LSU_ALIGN_CHECK_EN
    vt.push_back('{0, WORD, 0, 32'hBFC0_0002, 0, 0, 1, 1, 4'b0000, 0, 32'h0});
    vt.push_back('{0, HALF, 0, 32'hBFC0_0013, 0, 0, 1, 1, 4'b0000, 0, 32'h0});
`else
    vt.push_back('{0, WORD, 0, 32'hBFC0_0002, 0, 0, 0, 3, 4'b1111, 0, 32'h8011_2233});
    vt.push_back('{0, HALF, 0, 32'hBFC0_0013, 0, 0, 0, 3, 4'b1100, 0, 32'h0000_1234});
`endif

    foreach (vt[i]) begin
      do_txn(vt[i].wr, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, vt[i].mode, o);
      check_txn($sformatf("row%0d", i), vt[i].wr, vt[i].a, o, vt[i].err,
                vt[i].lat, vt[i].be, vt[i].bwd, vt[i].rd);
      if (vt[i].wr && !vt[i].err) ref_store(vt[i].a, vt[i].sz, vt[i].wd);
    end

    // stall timeout
    do_txn(1'b0, WORD, 1'b0, 32'hBFC0_0040, 32'h0, 3, o);
    chk("tmo_lat", 32'(o.lat), 32'(MW + 1));
    chk("tmo_err", 32'(o.err), 32'd1);
    chk("tmo_rd0", o.rd, 32'd0);
    chk("tmo_strobes", 32'(o.strobes), 32'(MW));
    chk("tmo_idle", {30'd0, read, busy}, 32'd0);

    // back-to-back: load accepted in the store's resp_valid cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = WORD; req_signed = 1'b0;
    req_addr = 32'hBFC0_0080; req_wdata = 32'hCAFE_F00D; waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_store_resp", 32'(resp_valid), 32'd1);
    ref_store(32'hBFC0_0080, WORD, 32'hCAFE_F00D);
    req_valid = 1'b1; req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_accept", {30'd0, busy, read}, 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_load_resp", 32'(resp_valid), 32'd1);
    chk("b2b_load_rd", resp_rdata, ref_load(32'hBFC0_0080, WORD, 1'b0));
    held = resp_rdata;
    @(negedge clk);
    chk("hold_pulse", 32'(resp_valid), 32'd0);
    chk("hold_rdata", resp_rdata, held);

    // reset in ACCESS, then in CAPTURE, then SW/LW to same address
    reset_mid(1);
    reset_mid(2);
    do_txn(1'b1, WORD, 1'b0, 32'hBFC0_0020, 32'h1357_9BDF, 0, o);
    chk("post_rst_sw", {31'd0, o.err}, 32'd0);
    ref_store(32'hBFC0_0020, WORD, 32'h1357_9BDF);
    do_txn(1'b0, WORD, 1'b0, 32'hBFC0_0020, 32'h0, 0, o);
    chk("post_rst_lw", o.rd, 32'h1357_9BDF);

    // randomized traffic against the byte-level reference
    for (int k = 0; k < 60; k++) begin
      wr   = 1'($urandom_range(0, 1));
      sz   = lsu_size_t'($urandom_range(0, 2));
      sg   = 1'($urandom_range(0, 1));
      a    = 32'hBFC0_0000 | 32'($urandom_range(0, 1023));
      wd   = $urandom();
      mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      e_err = ref_err(a, sz);
      do_txn(wr, sz, sg, a, wd, mode, o);
      check_txn($sformatf("rnd%0d", k), wr, a, o, e_err,
                e_err ? 1 : ((wr ? 2 : 3) + o.stalls),
                ref_be(a, sz), ref_wd(wd, sz), ref_load(a, sz, sg));
      if (wr && !e_err) ref_store(a, sz, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
